multdiv_ctrl: RTL and testbench

- Iterative multiply/divide execution unit. It sits beside the ALU in the X stage and produces the multdiv_is_running / multdiv_result_ready handshake consumed by the hazard/stall unit.
- Captures a mult/div instruction from the D/X latch and flushes it from the pipe. Computes over 32 iterations, then presents result, destination register and exception flag for one cycle to the writeback mux.

---
 rtl/multdiv_ctrl.sv | 170 +++++++++++++++++
 tb/tb_multdiv_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: iterative multiply/divide unit that sits beside the ALU in X.
// A mult/div in D/X is captured (and flushed from the pipe), computed over
// ITERS cycles, and presented for one cycle to the writeback mux.
//
// Ports:
//   clock, reset             rising-edge clock, async active-high reset
//   dx_ir_in                 D/X instruction: opcode [31:27], rd [26:22], ALU op [6:2]
//   dx_data_a, dx_data_b     bypassed rs / rt operands
//   dx_flush                 replace D/X instruction with nop at next edge
//   multdiv_is_running       operation in progress
//   multdiv_result_ready     one-cycle pulse qualifying the result outputs
//   multdiv_result           signed 32-bit result
//   multdiv_rd               destination register of the completed op
//   multdiv_exception        mult overflow or divide-by-zero
//   multdiv_is_div           completed op was a div
module multdiv_ctrl #(
    parameter logic [4:0] MULT_ALUOP = 5'b00110,
    parameter logic [4:0] DIV_ALUOP  = 5'b00111,
    parameter int         ITERS      = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] dx_ir_in,
    input  logic [31:0] dx_data_a,
    input  logic [31:0] dx_data_b,
    output logic        dx_flush,
    output logic        multdiv_is_running,
    output logic        multdiv_result_ready,
    output logic [31:0] multdiv_result,
    output logic [4:0]  multdiv_rd,
    output logic        multdiv_exception,
    output logic        multdiv_is_div
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state, w_next;
    logic [5:0]  r_cnt;
    logic        r_is_div_op, r_neg;
    logic [4:0]  r_rd_op;
    // Mult: r_acc = running product, r_a = shifted multiplicand, r_b = multiplier.
    // Div:  r_acc = {remainder, dividend/quotient}, r_b = divisor.
    logic [63:0] r_acc, r_a;
    logic [31:0] r_b;
    logic [31:0] r_result;
    logic [4:0]  r_rd;
    logic        r_exc, r_is_div;

    logic        w_start, w_is_div_in, w_last, w_div_zero, w_mult_ovf;
    logic [31:0] w_mag_a, w_mag_b, w_quo;
    logic [63:0] w_sh, w_sum, w_acc_next, w_a_next, w_prod;
    logic [31:0] w_b_next;
    logic        w_unused_ir;

    assign w_unused_ir = &{dx_ir_in[21:7], dx_ir_in[1:0]};

    assign w_start     = (dx_ir_in[31:27] == 5'd0) &&
                         ((dx_ir_in[6:2] == MULT_ALUOP) || (dx_ir_in[6:2] == DIV_ALUOP));
    assign w_is_div_in = (dx_ir_in[6:2] == DIV_ALUOP);
    assign w_last      = (r_cnt == 6'(ITERS - 1));

    // -0x80000000 wraps back to 0x80000000, which is the correct unsigned magnitude.
    assign w_mag_a = dx_data_a[31] ? -dx_data_a : dx_data_a;
    assign w_mag_b = dx_data_b[31] ? -dx_data_b : dx_data_b;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_RUN;
            S_RUN:   if (w_last)  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        dx_flush             = 1'b0;
        multdiv_is_running   = 1'b0;
        multdiv_result_ready = 1'b0;
        case (r_state)
            // Gated by reset so every output reads 0 while reset is held.
            S_IDLE:  dx_flush = w_start & ~reset;
            S_RUN:   multdiv_is_running = 1'b1;
            S_DONE:  multdiv_result_ready = 1'b1;
            default: ;
        endcase
    end

    // ---------------- one iteration of shift-add / restoring divide ----------------
    assign w_sh  = {r_acc[62:0], 1'b0};
    assign w_sum = r_acc + r_a;

    always_comb begin
        w_acc_next = r_acc;
        w_a_next   = r_a;
        w_b_next   = r_b;
        if (r_is_div_op) begin
            // Remainder stays below the divisor, so the shifted remainder fits 32 bits.
            if (w_sh[63:32] >= r_b) w_acc_next = {w_sh[63:32] - r_b, w_sh[31:1], 1'b1};
            else                    w_acc_next = w_sh;
        end else begin
            if (r_b[0]) w_acc_next = w_sum;
            w_a_next = {r_a[62:0], 1'b0};
            w_b_next = {1'b0, r_b[31:1]};
        end
    end

    // Final values derived from the last iteration so they land in the DONE cycle.
    assign w_prod     = r_neg ? -w_acc_next : w_acc_next;
    assign w_quo      = r_neg ? -w_acc_next[31:0] : w_acc_next[31:0];
    assign w_mult_ovf = (w_prod[63:32] != {32{w_prod[31]}});
    assign w_div_zero = (r_b == 32'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_is_div_op <= 1'b0;
            r_neg       <= 1'b0;
            r_rd_op     <= '0;
            r_acc       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_rd        <= '0;
            r_exc       <= 1'b0;
            r_is_div    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_a         <= {32'd0, w_mag_a};
                    r_b         <= w_mag_b;
                    r_acc       <= w_is_div_in ? {32'd0, w_mag_a} : 64'd0;
                    r_neg       <= dx_data_a[31] ^ dx_data_b[31];
                    r_rd_op     <= dx_ir_in[26:22];
                    r_is_div_op <= w_is_div_in;
                    r_cnt       <= '0;
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    r_a   <= w_a_next;
                    r_b   <= w_b_next;
                    r_cnt <= r_cnt + 6'd1;
                    if (w_last) begin
                        r_result <= r_is_div_op ? (w_div_zero ? 32'd0 : w_quo) : w_prod[31:0];
                        r_exc    <= r_is_div_op ? w_div_zero : w_mult_ovf;
                        r_rd     <= r_rd_op;
                        r_is_div <= r_is_div_op;
                    end
                end
                default: ;
            endcase
        end
    end

    assign multdiv_result    = r_result;
    assign multdiv_rd        = r_rd;
    assign multdiv_exception = r_exc;
    assign multdiv_is_div    = r_is_div;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl. Cycle 0 is the cycle in which an op sits in D/X.
module tb_multdiv_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] dx_ir_in, dx_data_a, dx_data_b;
    logic        dx_flush, multdiv_is_running, multdiv_result_ready;
    logic [31:0] multdiv_result;
    logic [4:0]  multdiv_rd;
    logic        multdiv_exception, multdiv_is_div;

    int checks = 0;
    int errors = 0;

    multdiv_ctrl dut (
        .clock(clock), .reset(reset),
        .dx_ir_in(dx_ir_in), .dx_data_a(dx_data_a), .dx_data_b(dx_data_b),
        .dx_flush(dx_flush), .multdiv_is_running(multdiv_is_running),
        .multdiv_result_ready(multdiv_result_ready), .multdiv_result(multdiv_result),
        .multdiv_rd(multdiv_rd), .multdiv_exception(multdiv_exception),
        .multdiv_is_div(multdiv_is_div)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mk_ir(input logic [4:0] rd, input logic isdiv);
        return {5'd0, rd, 15'd0, (isdiv ? 5'b00111 : 5'b00110), 2'b00};
    endfunction

    // Issue one op at cycle 0 and check flush, the RUN window, the DONE cycle and the hold after.
    task automatic do_op(input string name, input logic [4:0] rd, input logic isdiv,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ee);
        int bad;
        @(posedge clock); #1;
        dx_ir_in = mk_ir(rd, isdiv); dx_data_a = a; dx_data_b = b;
        @(negedge clock);
        checks++;
        if (dx_flush !== 1'b1 || multdiv_is_running !== 1'b0) begin
            errors++;
            $display("FAIL %s cycle0: flush=%b running=%b, required flush=1 running=0",
                     name, dx_flush, multdiv_is_running);
        end
        @(posedge clock); #1;
        dx_ir_in = 32'd0; dx_data_a = 32'd0; dx_data_b = 32'd0;
        bad = 0;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clock);
            if (multdiv_is_running !== 1'b1 || multdiv_result_ready !== 1'b0 || dx_flush !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s run window: %0d bad cycles in 1..32, required 0", name, bad);
        end
        @(negedge clock); // cycle 33
        checks++;
        if (multdiv_result_ready !== 1'b1 || multdiv_is_running !== 1'b0) begin
            errors++;
            $display("FAIL %s cycle33 handshake: ready=%b running=%b, required ready=1 running=0",
                     name, multdiv_result_ready, multdiv_is_running);
        end
        checks++;
        if (multdiv_result !== er) begin
            errors++;
            $display("FAIL %s result: got %h, required %h", name, multdiv_result, er);
        end
        checks++;
        if (multdiv_rd !== rd) begin
            errors++;
            $display("FAIL %s rd: got %0d, required %0d", name, multdiv_rd, rd);
        end
        checks++;
        if (multdiv_exception !== ee || multdiv_is_div !== isdiv) begin
            errors++;
            $display("FAIL %s flags: exc=%b is_div=%b, required exc=%b is_div=%b",
                     name, multdiv_exception, multdiv_is_div, ee, isdiv);
        end
        @(negedge clock); // cycle 34
        checks++;
        if (multdiv_result_ready !== 1'b0 || multdiv_result !== er) begin
            errors++;
            $display("FAIL %s cycle34 hold: ready=%b result=%h, required ready=0 result=%h",
                     name, multdiv_result_ready, multdiv_result, er);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        dx_ir_in = mk_ir(5'd4, 1'b0); dx_data_a = 32'd3; dx_data_b = 32'd4;
        repeat (2) @(negedge clock);
        checks++;
        if ({dx_flush, multdiv_is_running, multdiv_result_ready, multdiv_result,
             multdiv_rd, multdiv_exception, multdiv_is_div} !== 42'd0) begin
            errors++;
            $display("FAIL reset outputs: flush=%b run=%b rdy=%b res=%h rd=%0d exc=%b div=%b, required all 0",
                     dx_flush, multdiv_is_running, multdiv_result_ready, multdiv_result,
                     multdiv_rd, multdiv_exception, multdiv_is_div);
        end
        dx_ir_in = 32'd0; dx_data_a = 32'd0; dx_data_b = 32'd0;
        reset = 1'b0;
    endtask

    task automatic test_ignore();
        int bad = 0;
        @(posedge clock); #1;
        // Non-zero opcode with a mult ALU field, then a plain ALU op: neither may start.
        dx_ir_in = {5'b00101, 5'd3, 15'd0, 5'b00110, 2'b00};
        dx_data_a = 32'd5; dx_data_b = 32'd6;
        repeat (3) begin
            @(negedge clock);
            if (dx_flush !== 1'b0 || multdiv_is_running !== 1'b0) bad++;
        end
        dx_ir_in = {5'd0, 5'd3, 15'd0, 5'b00000, 2'b00};
        repeat (3) begin
            @(negedge clock);
            if (dx_flush !== 1'b0 || multdiv_is_running !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ignore non-multdiv: %0d bad cycles, required 0", bad);
        end
        dx_ir_in = 32'd0; dx_data_a = 32'd0; dx_data_b = 32'd0;
    endtask

    task automatic test_mult();
        do_op("mult_7x-3",  5'd5,  1'b0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
        do_op("mult_ovf",   5'd6,  1'b0, 32'h00010000,  32'h00010000, 32'h00000000, 1'b1);
        do_op("mult_min",   5'd7,  1'b0, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1'b1);
    endtask

    task automatic test_div();
        do_op("div_-100/7", 5'd9,  1'b1, 32'hFFFFFF9C,  32'd7,        32'hFFFFFFF2, 1'b0);
        do_op("div_by0",    5'd10, 1'b1, 32'd123,       32'd0,        32'd0,        1'b1);
        do_op("div_min/-1", 5'd11, 1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1'b0);
    endtask

    task automatic test_reset_mid_div();
        int bad = 0;
        @(posedge clock); #1;
        dx_ir_in = mk_ir(5'd13, 1'b1); dx_data_a = 32'd1000; dx_data_b = 32'd3;
        @(posedge clock); #1;
        dx_ir_in = 32'd0; dx_data_a = 32'd0; dx_data_b = 32'd0;
        repeat (9) @(posedge clock); // now inside cycle 10
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({dx_flush, multdiv_is_running, multdiv_result_ready, multdiv_result,
             multdiv_rd, multdiv_exception, multdiv_is_div} !== 42'd0) begin
            errors++;
            $display("FAIL reset mid-div outputs: run=%b rdy=%b res=%h rd=%0d exc=%b div=%b, required all 0",
                     multdiv_is_running, multdiv_result_ready, multdiv_result,
                     multdiv_rd, multdiv_exception, multdiv_is_div);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (multdiv_result_ready !== 1'b0 || multdiv_is_running !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset mid-div abandon: %0d cycles with ready/running, required 0", bad);
        end
        do_op("mult_after_reset", 5'd31, 1'b0, 32'd100, 32'd200, 32'd20000, 1'b0);
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        @(posedge clock); #1;
        dx_ir_in = mk_ir(5'd3, 1'b0); dx_data_a = 32'd6; dx_data_b = 32'd7;
        @(negedge clock);
        checks++;
        if (dx_flush !== 1'b1) begin
            errors++;
            $display("FAIL b2b first flush: got %b, required 1", dx_flush);
        end
        @(posedge clock); #1; // cycle 1: second op held in D/X from here on
        dx_ir_in = mk_ir(5'd12, 1'b0); dx_data_a = 32'hFFFFFFFB; dx_data_b = 32'hFFFFFFF7;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clock);
            if (multdiv_is_running !== 1'b1 || dx_flush !== 1'b0) bad++;
        end
        @(negedge clock); // cycle 33
        if (dx_flush !== 1'b0) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL b2b first run: %0d bad cycles (flush in RUN/DONE or not running), required 0", bad);
        end
        checks++;
        if (multdiv_result_ready !== 1'b1 || multdiv_result !== 32'd42 || multdiv_rd !== 5'd3) begin
            errors++;
            $display("FAIL b2b first result: rdy=%b res=%h rd=%0d, required rdy=1 res=0000002a rd=3",
                     multdiv_result_ready, multdiv_result, multdiv_rd);
        end
        @(negedge clock); // cycle 34
        checks++;
        if (dx_flush !== 1'b1 || multdiv_result_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b capture cycle34: flush=%b rdy=%b, required flush=1 rdy=0",
                     dx_flush, multdiv_result_ready);
        end
        @(posedge clock); #1;
        dx_ir_in = 32'd0; dx_data_a = 32'd0; dx_data_b = 32'd0;
        bad = 0;
        for (int c = 35; c <= 66; c++) begin
            @(negedge clock);
            if (multdiv_is_running !== 1'b1 || multdiv_result_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL b2b second run: %0d bad cycles in 35..66, required 0", bad);
        end
        @(negedge clock); // cycle 67
        checks++;
        if (multdiv_result_ready !== 1'b1 || multdiv_result !== 32'd45 ||
            multdiv_rd !== 5'd12 || multdiv_exception !== 1'b0) begin
            errors++;
            $display("FAIL b2b second result: rdy=%b res=%h rd=%0d exc=%b, required rdy=1 res=0000002d rd=12 exc=0",
                     multdiv_result_ready, multdiv_result, multdiv_rd, multdiv_exception);
        end
    endtask

    initial begin
        test_reset();
        test_ignore();
        test_mult();
        test_div();
        test_reset_mid_div();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
